// File: rtl/lfsr_prng_if.sv
// Sample handshake bundle for lfsr_prng.
//   sample        random sample captured on each LFSR step or lockup recovery
//   sample_valid  sample holds data the consumer has not yet taken
//   sample_ready  consumer accepts the sample on an edge where sample_valid is high
// master: the generator (drives sample/sample_valid); slave: the consumer.
interface lfsr_prng_if #(
  parameter int OUT_W = 4
) ();
  logic [OUT_W-1:0] sample;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/lfsr_prng.sv
// Paced pseudo-random generator built on a selectable Fibonacci-XNOR or
// Galois-XOR LFSR. A tick counter advances the LFSR once every `period`
// clocks. Each step publishes the low OUT_W bits of the new state through a
// valid/ready sample port, and an overwrite of unconsumed data is flagged.
//
// Ports:
//   clock       rising-edge clock for all state
//   reset       synchronous, active-high reset
//   hold        freezes tick counter and LFSR (sample handshake keeps running)
//   period      clocks per LFSR step; 0 behaves like 1
//   mode        0 = Fibonacci XNOR, 1 = Galois XOR
//   seed_load   load seed into the LFSR and restart the period
//   seed        value loaded by seed_load
//   state       current LFSR register
//   step_pulse  one-cycle pulse in the cycle the new state first appears
//   lockup      state is the stuck value for the current mode (combinational)
//   overrun     sticky: a sample was replaced before being consumed
//   smp         sample handshake (master side)
module lfsr_prng #(
  parameter int WIDTH    = 16,
  parameter int PERIOD_W = 10,
  parameter int OUT_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hold,
  input  logic [PERIOD_W-1:0] period,
  input  logic                mode,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed,
  output logic [WIDTH-1:0]    state,
  output logic                step_pulse,
  output logic                lockup,
  output logic                overrun,
  lfsr_prng_if.master         smp
);

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be 8, 16, 24 or 32");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_prng: OUT_W must be in 1..WIDTH");
  end

  // Fibonacci tap positions expressed as a bit mask (tap n -> bit n-1).
  localparam logic [31:0] FIB_TAPS_32 =
      (WIDTH == 8)  ? 32'h0000_00B8 :
      (WIDTH == 16) ? 32'h0000_D008 :
      (WIDTH == 24) ? 32'h00E1_0000 :
                      32'h8020_0003;

  // Galois feedback mask applied when the bit shifted out is 1.
  localparam logic [31:0] GAL_MASK_32 =
      (WIDTH == 8)  ? 32'h0000_00B8 :
      (WIDTH == 16) ? 32'h0000_B400 :
      (WIDTH == 24) ? 32'h00E1_0000 :
                      32'h8020_0003;

  localparam logic [WIDTH-1:0] FIB_TAPS = FIB_TAPS_32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] GAL_MASK = GAL_MASK_32[WIDTH-1:0];

  logic [PERIOD_W-1:0] count;
  logic                tick;
  logic                capture;
  logic [WIDTH-1:0]    stepped;
  logic [WIDTH-1:0]    mode_reset_value;
  logic [WIDTH-1:0]    next_value;

  // NOTE: every signal written here gets a value on every path through the
  // block, so no latch can be inferred.
  always_comb begin
    // All-ones is the stuck point of the XNOR form, all-zeros of the XOR form.
    lockup           = mode ? (state == '0) : (state == '1);
    tick             = (period <= PERIOD_W'(1)) || (count == period - PERIOD_W'(1));
    mode_reset_value = WIDTH'(mode);

    if (mode) begin
      stepped = (state >> 1) ^ (state[0] ? GAL_MASK : '0);
    end else begin
      stepped = {state[WIDTH-2:0], ~^(state & FIB_TAPS)};
    end

    // A tick on a stuck state recovers instead of stepping.
    next_value = lockup ? mode_reset_value : stepped;

    // seed_load and hold both pre-empt the tick.
    capture = !seed_load && !hold && tick;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count             <= '0;
      state             <= WIDTH'(mode);
      step_pulse        <= 1'b0;
      overrun           <= 1'b0;
      smp.sample        <= '0;
      smp.sample_valid  <= 1'b0;
    end else begin
      step_pulse <= capture;

      if (seed_load) begin
        count <= '0;
        state <= seed;
      end else if (!hold) begin
        if (tick) begin
          count <= '0;
          state <= next_value;
        end else begin
          count <= count + PERIOD_W'(1);
        end
      end

      if (seed_load) begin
        overrun <= 1'b0;
      end else if (capture && smp.sample_valid && !smp.sample_ready) begin
        overrun <= 1'b1;
      end

      // A capture on the same edge as a transfer keeps valid high with the
      // new data; otherwise a transfer empties the slot.
      if (capture) begin
        smp.sample       <= next_value[OUT_W-1:0];
        smp.sample_valid <= 1'b1;
      end else if (smp.sample_ready) begin
        smp.sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng at WIDTH=16, PERIOD_W=10, OUT_W=4.
// A behavioural model tracks the expected outputs and is compared every
// cycle; directed literal checks pin the model to known sequences.
module tb_lfsr_prng;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic [9:0]  period;
  logic        mode;
  logic        seed_load;
  logic [15:0] seed;
  logic [15:0] state;
  logic        step_pulse;
  logic        lockup;
  logic        overrun;

  lfsr_prng_if #(.OUT_W(4)) smp_if ();

  lfsr_prng #(.WIDTH(16), .PERIOD_W(10), .OUT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .hold       (hold),
    .period     (period),
    .mode       (mode),
    .seed_load  (seed_load),
    .seed       (seed),
    .state      (state),
    .step_pulse (step_pulse),
    .lockup     (lockup),
    .overrun    (overrun),
    .smp        (smp_if)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state, m_count, m_sample;
  bit m_valid, m_ovr, m_pulse;

  function automatic int model_next(input int s, input bit m);
    int taps[4] = '{16, 15, 13, 4};
    int fb;
    if (m) return (s & 1) ? ((s >> 1) ^ 'hB400) : (s >> 1);
    fb = 1;  // XNOR of taps = 1 xor each tap
    foreach (taps[i]) fb ^= (s >> (taps[i] - 1)) & 1;
    return ((s << 1) | fb) & 'hFFFF;
  endfunction

  function automatic bit model_illegal(input int s, input bit m);
    return m ? (s == 0) : (s == 'hFFFF);
  endfunction

  always @(posedge clock) begin : model
    bit cap;
    int eff;
    cap     = 1'b0;
    m_pulse = 1'b0;
    if (reset) begin
      m_count  = 0;
      m_state  = mode ? 1 : 0;
      m_sample = 0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      if (seed_load) begin
        m_state = int'(seed);
        m_count = 0;
        m_ovr   = 1'b0;
      end else if (!hold) begin
        eff = (period == 0) ? 1 : int'(period);
        if (m_count == eff - 1 || eff == 1) begin
          m_count = 0;
          m_state = model_illegal(m_state, mode) ? (mode ? 1 : 0) : model_next(m_state, mode);
          cap     = 1'b1;
        end else begin
          m_count = m_count + 1;
        end
      end
      if (cap) begin
        if (m_valid && !smp_if.sample_ready) m_ovr = 1'b1;
        m_sample = m_state & 'hF;
        m_valid  = 1'b1;
        m_pulse  = 1'b1;
      end else if (m_valid && smp_if.sample_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("state",        32'(state),               32'(m_state));
      check("lockup",       32'(lockup),              32'(model_illegal(m_state, mode)));
      check("step_pulse",   32'(step_pulse),          32'(m_pulse));
      check("sample",       32'(smp_if.sample),       32'(m_sample));
      check("sample_valid", 32'(smp_if.sample_valid), 32'(m_valid));
      check("overrun",      32'(overrun),             32'(m_ovr));
    end
  end

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; mode = 1'b0; seed_load = 1'b0;
    seed = 16'h0000; period = 10'd10; smp_if.sample_ready = 1'b1;
    cyc(2);
    check("rst_state",   32'(state), 32'h0);
    check("rst_valid",   32'(smp_if.sample_valid), 32'h0);
    check("rst_pulse",   32'(step_pulse), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_sample",  32'(smp_if.sample), 32'h0);
    cmp_en = 1'b1;

    // Fibonacci, period 10
    reset = 1'b0;
    cyc(9);
    check("fib_before_step", 32'(state), 32'h0);
    cyc(1);
    check("fib_s1",  32'(state), 32'h0001);
    check("fib_p1",  32'(step_pulse), 32'h1);
    cyc(10);
    check("fib_s2",  32'(state), 32'h0003);
    cyc(10);
    check("fib_s3",  32'(state), 32'h0007);

    // Galois, period 1
    reset = 1'b1; mode = 1'b1; period = 10'd1;
    cyc(1);
    check("gal_rst", 32'(state), 32'h0001);
    reset = 1'b0;
    cyc(1); check("gal_s1", 32'(state), 32'hB400);
    cyc(1); check("gal_s2", 32'(state), 32'h5A00);
    cyc(1); check("gal_s3", 32'(state), 32'h2D00);

    // Fibonacci lockup recovery
    mode = 1'b0; seed_load = 1'b1; seed = 16'hFFFF;
    cyc(1);
    seed_load = 1'b0;
    check("lock_state", 32'(state), 32'hFFFF);
    check("lock_flag",  32'(lockup), 32'h1);
    cyc(1);
    check("recov_state",  32'(state), 32'h0000);
    check("recov_lockup", 32'(lockup), 32'h0);
    check("recov_sample", 32'(smp_if.sample), 32'h0);

    // hold at count 5 for 20 clocks
    period = 10'd10; seed_load = 1'b1; seed = 16'h1234;
    cyc(1);
    seed_load = 1'b0;
    check("seed_state", 32'(state), 32'h1234);
    cyc(5);
    hold = 1'b1;
    cyc(20);
    check("hold_state", 32'(state), 32'h1234);
    check("hold_pulse", 32'(step_pulse), 32'h0);
    hold = 1'b0;
    cyc(4);
    check("hold_after4", 32'(state), 32'h1234);
    cyc(1);
    check("hold_step",  32'(state), 32'h2468);
    check("hold_pulse2", 32'(step_pulse), 32'h1);

    // overrun with ready low for three steps
    period = 10'd1; smp_if.sample_ready = 1'b0;
    cyc(3);
    check("ovr_state",  32'(state), 32'h2341);
    check("ovr_sample", 32'(smp_if.sample), 32'h1);
    check("ovr_flag",   32'(overrun), 32'h1);
    hold = 1'b1; smp_if.sample_ready = 1'b1;
    cyc(1);
    check("ovr_valid_clr", 32'(smp_if.sample_valid), 32'h0);
    check("ovr_sticky",    32'(overrun), 32'h1);
    hold = 1'b0;

    // period 0 behaves as period 1; seed_load clears overrun
    period = 10'd0; seed_load = 1'b1; seed = 16'h0000;
    cyc(1);
    seed_load = 1'b0;
    check("p0_ovr_clr", 32'(overrun), 32'h0);
    cyc(1); check("p0_s1", 32'(state), 32'h0001);
    cyc(1); check("p0_s2", 32'(state), 32'h0003);
    cyc(1); check("p0_s3", 32'(state), 32'h0007);
    smp_if.sample_ready = 1'b0;
    cyc(2);
    check("p0_ovr", 32'(overrun), 32'h1);
    reset = 1'b1; mode = 1'b1;
    cyc(1);
    check("mid_rst_state", 32'(state), 32'h0001);
    check("mid_rst_valid", 32'(smp_if.sample_valid), 32'h0);
    check("mid_rst_ovr",   32'(overrun), 32'h0);
    check("mid_rst_pulse", 32'(step_pulse), 32'h0);

    // Galois lockup recovery
    reset = 1'b0; smp_if.sample_ready = 1'b1; seed_load = 1'b1; seed = 16'h0000;
    cyc(1);
    seed_load = 1'b0;
    check("gal_lock", 32'(lockup), 32'h1);
    cyc(1);
    check("gal_recov", 32'(state), 32'h0001);
    check("gal_recov_lock", 32'(lockup), 32'h0);

    // randomised stretch checked against the model
    seed_load = 1'b1; seed = 16'hACE1; period = 10'd3;
    cyc(1);
    seed_load = 1'b0;
    for (int i = 0; i < 300; i++) begin
      smp_if.sample_ready = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      cyc(1);
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_prng.md
LFSR_PRNG -- requirements
Module: lfsr_prng

Interface
REQ-001 Parameter WIDTH, default 16, LFSR state width; legal values 8, 16, 24 and 32 only.
REQ-002 Parameter PERIOD_W, default 10, width of the step-period input and internal tick counter.
REQ-003 Parameter OUT_W, default 4, width of the sample port; 1 <= OUT_W <= WIDTH.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 hold  in  1  freezes tick counter and LFSR state while high.
REQ-007 period  in  PERIOD_W  clocks per LFSR step; 0 treated as 1.
REQ-008 mode  in  1  0 = Fibonacci XNOR, 1 = Galois XOR.
REQ-009 seed_load  in  1  load seed into state at next edge.
REQ-010 seed  in  WIDTH  seed value.
REQ-011 state  out  WIDTH  current LFSR register.
REQ-012 sample  out  OUT_W  captured random sample.
REQ-013 sample_valid  out  1  sample holds unconsumed data.
REQ-014 sample_ready  in  1  consumer accepts sample when high with sample_valid.
REQ-015 step_pulse  out  1  high for exactly one cycle after each LFSR step.
REQ-016 lockup  out  1  combinational; high when state is the illegal value for current mode.
REQ-017 overrun  out  1  sticky; a sample was replaced before being consumed.

Function
REQ-018 Tick counter SHALL count 0..period-1 when hold=0; tick asserted when count==period-1 (or period<=1), count then returns to 0.
REQ-019 Edge priority: reset > seed_load > hold > tick.
REQ-020 seed_load SHALL load state=seed and clear count, regardless of hold; no step that cycle.
REQ-021 Mode 0 step: state shifts left one bit; bit0 = XNOR of tap bits; taps (1-indexed): 8:{8,6,5,4}, 16:{16,15,13,4}, 24:{24,23,22,17}, 32:{32,22,2,1}.
REQ-022 Mode 1 step: state = (state >> 1) XOR (state[0] ? MASK : 0); MASK 8:0xB8, 16:0xB400, 24:0xE10000, 32:0x80200003.
REQ-023 Illegal value: all-ones in mode 0, all-zeros in mode 1; lockup SHALL reflect it in the same cycle.
REQ-024 On a tick while lockup=1, state SHALL load the mode's reset value (mode 0: 0; mode 1: 1) instead of stepping.
REQ-025 mode change SHALL take effect on the next tick with no other side effect.
REQ-026 On every step or lockup recovery, sample SHALL capture the new state[OUT_W-1:0] and sample_valid SHALL be 1 from the next cycle.
REQ-027 Transfer occurs on an edge with sample_valid=1 and sample_ready=1; sample_valid then clears unless a new sample is captured on the same edge, in which case it stays 1 with the new data.
REQ-028 Capture while sample_valid=1 and sample_ready=0 SHALL overwrite sample and set overrun; overrun clears only on reset or seed_load.
REQ-029 hold SHALL NOT affect the sample handshake.
REQ-030 step_pulse SHALL be registered, high in the cycle in which state first shows the stepped value.

Reset
REQ-031 On reset: count=0, state=0 (mode 0) or 1 (mode 1), sample=0, sample_valid=0, step_pulse=0, overrun=0.
REQ-032 Reset mid-count or mid-handshake SHALL discard pending sample and restart the period from count 0.

Verification
REQ-033 WIDTH=16, mode 0, period 10, release reset -> state 0x0001 ten clocks later with step_pulse, then 0x0003, 0x0007 at 10-clock intervals.
REQ-034 mode 1, period 1, after reset -> state sequence 0x0001, 0xB400, 0x5A00, 0x2D00 on consecutive clocks.
REQ-035 mode 0, seed_load with seed 0xFFFF -> lockup=1; next tick state=0x0000, lockup=0, sample=0x0.
REQ-036 period 10, hold raised at count 5 for 20 clocks -> state and count frozen; step occurs 5 clocks after hold falls.
REQ-037 period 1, sample_ready=0 for 3 steps -> overrun=1, sample = latest state[3:0]; raise ready -> valid clears next cycle, overrun stays 1.
REQ-038 period 0 -> steps every clock, identical to period 1; reset asserted mid-run -> REQ-031 values on the next edge.
